exc_ctrl: RTL and testbench

- Exception/interrupt sequencer sitting after the MEM stage; the consumer and writer side of the CP0 register block.
- Reads forwarded Status/Cause/EPC and decides whether an interrupt, synchronous exception or ERET is taken.
- Commits the required CP0 updates one word per cycle through CP0's single write port (we/waddr/data).
- Then issues a one-cycle pipeline flush with the redirect PC.

---
 rtl/exc_ctrl_pkg.sv | 31 +++
 rtl/exc_prio_enc.sv | 37 +++
 rtl/exc_ctrl.sv | 135 +++++++++++++
 tb/tb_exc_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared CP0 addresses, exception codes and FSM encoding for exc_ctrl
package exc_ctrl_pkg;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;
   localparam logic [4:0] EXC_TR  = 5'd13;

   localparam int ET_SYSCALL  = 8;
   localparam int ET_RESERVED = 9;
   localparam int ET_TRAP     = 10;
   localparam int ET_OVERFLOW = 11;
   localparam int ET_ERET     = 12;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_EPC    = 3'd1,
      S_W_CAUSE  = 3'd2,
      S_W_STATUS = 3'd3,
      S_REDIRECT = 3'd4
   } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - combinational interrupt/exception/eret priority encoder
module exc_prio_enc
   import exc_ctrl_pkg::*;
(
   input  logic [31:0] i_excepttype,
   input  logic [31:0] i_status,
   input  logic [31:0] i_cause,
   output logic        o_take,
   output logic        o_is_eret,
   output logic [4:0]  o_exccode
);

   logic w_int_pending;
   logic w_unused_bits;

   assign w_int_pending = i_status[ST_IE] & ~i_status[ST_EXL] &
                          (|(i_cause[15:8] & i_status[15:8]));

   assign w_unused_bits = ^{i_excepttype[31:13], i_excepttype[7:0],
                            i_status[31:16], i_status[7:2],
                            i_cause[31:16], i_cause[7:0]};

   always_comb begin
      o_take    = 1'b1;
      o_exccode = EXC_INT;
      if (w_int_pending)                  o_exccode = EXC_INT;
      else if (i_excepttype[ET_SYSCALL])  o_exccode = EXC_SYS;
      else if (i_excepttype[ET_RESERVED]) o_exccode = EXC_RI;
      else if (i_excepttype[ET_TRAP])     o_exccode = EXC_TR;
      else if (i_excepttype[ET_OVERFLOW]) o_exccode = EXC_OV;
      else                                o_take    = 1'b0;
   end

   // Any exception or interrupt outranks an eret flagged on the same instruction.
   assign o_is_eret = ~o_take & i_excepttype[ET_ERET];

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/eret sequencer writing CP0 then flushing; EXC_STATS_EN adds exc_count_o
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter bit          ERET_CLR_EXL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] inst_addr_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_data_o,
   output logic        stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
`ifdef EXC_STATS_EN
   ,
   output logic [15:0] exc_count_o
`endif
);

   state_t      r_state, w_next;
   logic        w_take, w_is_eret;
   logic [4:0]  w_exccode;
   logic        w_capture;

   logic [4:0]  r_exccode;
   logic [31:0] r_epc_val, r_status, r_cause, r_epc;
   logic        r_bd, r_skip_epc, r_is_eret;

   exc_prio_enc u_prio (
      .i_excepttype (excepttype_i),
      .i_status     (cp0_status_i),
      .i_cause      (cp0_cause_i),
      .o_take       (w_take),
      .o_is_eret    (w_is_eret),
      .o_exccode    (w_exccode)
   );

   assign w_capture = (r_state == S_IDLE) & mem_valid_i & (w_take | w_is_eret);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_exccode  <= '0;
         r_epc_val  <= '0;
         r_status   <= '0;
         r_cause    <= '0;
         r_epc      <= '0;
         r_bd       <= 1'b0;
         r_skip_epc <= 1'b0;
         r_is_eret  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_exccode  <= w_exccode;
            r_epc_val  <= in_delayslot_i ? (inst_addr_i - 32'd4) : inst_addr_i;
            r_bd       <= in_delayslot_i;
            r_status   <= cp0_status_i;
            r_cause    <= cp0_cause_i;
            r_epc      <= cp0_epc_i;
            r_skip_epc <= w_take & cp0_status_i[ST_EXL];
            r_is_eret  <= w_is_eret;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      cp0_we_o    = 1'b0;
      cp0_waddr_o = '0;
      cp0_data_o  = '0;
      flush_o     = 1'b0;
      new_pc_o    = '0;
      case (r_state)
         S_IDLE: begin
            if (w_capture) begin
               if (w_take)            w_next = cp0_status_i[ST_EXL] ? S_W_CAUSE : S_W_EPC;
               else if (ERET_CLR_EXL) w_next = S_W_STATUS;
               else                   w_next = S_REDIRECT;
            end
         end
         S_W_EPC: begin
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_EPC;
            cp0_data_o  = r_epc_val;
            w_next      = S_W_CAUSE;
         end
         S_W_CAUSE: begin
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_CAUSE;
            // A nested exception (EXL already set) must not disturb the original BD.
            cp0_data_o  = {(r_skip_epc ? r_cause[31] : r_bd), r_cause[30:7],
                           r_exccode, r_cause[1:0]};
            w_next      = S_W_STATUS;
         end
         S_W_STATUS: begin
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_STATUS;
            cp0_data_o  = r_is_eret ? (r_status & ~32'h2) : (r_status | 32'h2);
            w_next      = S_REDIRECT;
         end
         S_REDIRECT: begin
            flush_o  = 1'b1;
            new_pc_o = r_is_eret ? r_epc : EXC_VECTOR;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // The flush cycle itself releases the stall so the redirect can be fetched.
   assign stall_o = (r_state != S_IDLE) && (r_state != S_REDIRECT);

`ifdef EXC_STATS_EN
   logic [15:0] r_exc_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_exc_count <= '0;
      else if ((r_state == S_W_STATUS) && !r_is_eret && (r_exc_count != 16'hFFFF))
         r_exc_count <= r_exc_count + 16'd1;
   end

   assign exc_count_o = r_exc_count;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_valid_i = 1'b0;
   logic [31:0] excepttype_i = '0;
   logic [31:0] inst_addr_i = '0;
   logic        in_delayslot_i = 1'b0;
   logic [31:0] cp0_status_i = '0;
   logic [31:0] cp0_cause_i = '0;
   logic [31:0] cp0_epc_i = '0;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_data_o;
   logic        stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
`ifdef EXC_STATS_EN
   logic [15:0] exc_count_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   exc_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid_i    (mem_valid_i),
      .excepttype_i   (excepttype_i),
      .inst_addr_i    (inst_addr_i),
      .in_delayslot_i (in_delayslot_i),
      .cp0_status_i   (cp0_status_i),
      .cp0_cause_i    (cp0_cause_i),
      .cp0_epc_i      (cp0_epc_i),
      .cp0_we_o       (cp0_we_o),
      .cp0_waddr_o    (cp0_waddr_o),
      .cp0_data_o     (cp0_data_o),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .new_pc_o       (new_pc_o)
`ifdef EXC_STATS_EN
      ,
      .exc_count_o    (exc_count_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks every output at the current falling edge, then steps one cycle.
   task automatic cyc(input string tag, input logic we, input logic [4:0] wa,
                      input logic [31:0] d, input logic st, input logic fl,
                      input logic [31:0] pc);
      chk({tag, ".we"},    {31'd0, cp0_we_o},    {31'd0, we});
      chk({tag, ".waddr"}, {27'd0, cp0_waddr_o}, {27'd0, wa});
      chk({tag, ".data"},  cp0_data_o,           d);
      chk({tag, ".stall"}, {31'd0, stall_o},     {31'd0, st});
      chk({tag, ".flush"}, {31'd0, flush_o},     {31'd0, fl});
      chk({tag, ".newpc"}, new_pc_o,             pc);
      @(negedge clk);
   endtask

   // Presents one MEM-stage instruction for a single rising edge.
   task automatic present(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                          input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
      mem_valid_i    = 1'b1;
      excepttype_i   = et;
      inst_addr_i    = pc;
      in_delayslot_i = ds;
      cp0_status_i   = st;
      cp0_cause_i    = ca;
      cp0_epc_i      = ep;
      @(negedge clk);
      mem_valid_i    = 1'b0;
      excepttype_i   = 32'h0;
      in_delayslot_i = 1'b0;
   endtask

   initial begin
      #2;
      cyc("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // Overflow, no delay slot
      present(32'h0000_0800, 32'h0000_1000, 1'b0, 32'h1000_0001, 32'h0, 32'h0);
      cyc("ov.epc",    1'b1, 5'd14, 32'h0000_1000, 1'b1, 1'b0, 32'h0);
      cyc("ov.cause",  1'b1, 5'd13, 32'h0000_0030, 1'b1, 1'b0, 32'h0);
      cyc("ov.status", 1'b1, 5'd12, 32'h1000_0003, 1'b1, 1'b0, 32'h0);
      cyc("ov.flush",  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h20);
      cyc("ov.idle",   1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0);

      // Syscall in delay slot
      present(32'h0000_0100, 32'h0000_2004, 1'b1, 32'h0000_0001, 32'h0, 32'h0);
      cyc("sys.epc",    1'b1, 5'd14, 32'h0000_2000, 1'b1, 1'b0, 32'h0);
      cyc("sys.cause",  1'b1, 5'd13, 32'h8000_0020, 1'b1, 1'b0, 32'h0);
      cyc("sys.status", 1'b1, 5'd12, 32'h0000_0003, 1'b1, 1'b0, 32'h0);
      cyc("sys.flush",  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h20);

      // Interrupt on a plain instruction
      present(32'h0, 32'h0000_3000, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0);
      cyc("int.epc",    1'b1, 5'd14, 32'h0000_3000, 1'b1, 1'b0, 32'h0);
      cyc("int.cause",  1'b1, 5'd13, 32'h0000_0400, 1'b1, 1'b0, 32'h0);
      cyc("int.status", 1'b1, 5'd12, 32'h0000_0403, 1'b1, 1'b0, 32'h0);
      cyc("int.flush",  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h20);

      // Same interrupt masked by EXL: nothing happens
      present(32'h0, 32'h0000_3000, 1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0);
      cyc("intexl.c1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
      cyc("intexl.c2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);

      // ERET
      present(32'h0000_1000, 32'h0000_5000, 1'b0, 32'h0000_0003, 32'h0, 32'h0000_3000);
      cyc("eret.status", 1'b1, 5'd12, 32'h0000_0001, 1'b1, 1'b0, 32'h0);
      cyc("eret.flush",  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h3000);
      cyc("eret.idle",   1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 32'h0);

      // Reserved-instr + overflow + eret together: reserved-instr wins
      present(32'h0000_1A00, 32'h0000_6000, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_7000);
      cyc("prio.epc",    1'b1, 5'd14, 32'h0000_6000, 1'b1, 1'b0, 32'h0);
      cyc("prio.cause",  1'b1, 5'd13, 32'h0000_0028, 1'b1, 1'b0, 32'h0);
      cyc("prio.status", 1'b1, 5'd12, 32'h0000_0002, 1'b1, 1'b0, 32'h0);
      cyc("prio.flush",  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h20);

      // Trap with EXL already set: EPC skipped, old BD kept
      present(32'h0000_0400, 32'h0000_4000, 1'b0, 32'h0000_0003, 32'h8000_0000, 32'h0);
      cyc("trap.cause",  1'b1, 5'd13, 32'h8000_0034, 1'b1, 1'b0, 32'h0);
      cyc("trap.status", 1'b1, 5'd12, 32'h0000_0003, 1'b1, 1'b0, 32'h0);
      cyc("trap.flush",  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h20);
`ifdef EXC_STATS_EN
      chk("stats.five", {16'd0, exc_count_o}, 32'd5);
`endif

      // Reset pulse during W_CAUSE
      present(32'h0000_0800, 32'h0000_8000, 1'b0, 32'h0000_0001, 32'h0, 32'h0);
      cyc("rst.epc", 1'b1, 5'd14, 32'h0000_8000, 1'b1, 1'b0, 32'h0);
      chk("rst.in_cause_we", {31'd0, cp0_we_o}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst.async_we",    {31'd0, cp0_we_o}, 32'd0);
      chk("rst.async_stall", {31'd0, stall_o},  32'd0);
      chk("rst.async_flush", {31'd0, flush_o},  32'd0);
`ifdef EXC_STATS_EN
      chk("stats.cleared", {16'd0, exc_count_o}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      cyc("rst.quiet1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
      cyc("rst.quiet2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);

      // Normal sequencing after reset
      present(32'h0000_0100, 32'h0000_9000, 1'b0, 32'h0000_0001, 32'h0, 32'h0);
      cyc("post.epc",    1'b1, 5'd14, 32'h0000_9000, 1'b1, 1'b0, 32'h0);
      cyc("post.cause",  1'b1, 5'd13, 32'h0000_0020, 1'b1, 1'b0, 32'h0);
      cyc("post.status", 1'b1, 5'd12, 32'h0000_0003, 1'b1, 1'b0, 32'h0);
      cyc("post.flush",  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h20);
`ifdef EXC_STATS_EN
      chk("stats.one", {16'd0, exc_count_o}, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
